// File: rtl/jelly_img_ss_sqrt_if.sv
// Image stream bundle carrying sideband, x/y and either the sum of squares (input side) or magnitude/remainder (output side).
// Latency: none, wires only.
// Backpressure: none; the stream is qualified by the owner's clock enable.
//
// Modports:
//   slave  - consumer of the sum-of-squares stream (flags, user, x, y, ss, valid)
//   master - producer of the magnitude stream (flags, user, x, y, mag, rem, valid)
interface jelly_img_ss_sqrt_if #(
    parameter int USER_BITS  = 1,
    parameter int DATA_WIDTH = 8
) ();
    logic                          line_first;
    logic                          line_last;
    logic                          pixel_first;
    logic                          pixel_last;
    logic                          de;
    logic [USER_BITS-1:0]          user;
    logic signed [DATA_WIDTH-1:0]  x;
    logic signed [DATA_WIDTH-1:0]  y;
    logic [2*DATA_WIDTH-1:0]       ss;
    logic [DATA_WIDTH:0]           mag;
    logic [DATA_WIDTH:0]           rem;
    logic                          valid;

    modport slave (
        input line_first, line_last, pixel_first, pixel_last, de,
        input user, x, y, ss, valid
    );

    modport master (
        output line_first, line_last, pixel_first, pixel_last, de,
        output user, x, y, mag, rem, valid
    );
endinterface

// File: rtl/jelly_img_ss_sqrt.sv
// Streaming restoring integer square root of x^2+y^2, one root bit per stage, sideband and x/y delayed alongside.
// Latency: DATA_WIDTH+2 enabled cycles (input register, DATA_WIDTH root stages, round/output register).
// Backpressure: none; cke=0 freezes every register including the sideband delay.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-low; clears every register regardless of cke
//   cke    - clock enable for the whole pipeline
//   s_img  - input stream (flags, user, x, y, ss, valid)
//   m_img  - output stream (delayed flags, user, x, y, mag, floor remainder, valid)
module jelly_img_ss_sqrt #(
    parameter int USER_WIDTH = 0,
    parameter int DATA_WIDTH = 8,
    parameter int USE_VALID  = 0,
    parameter int ROUNDING   = 0,
    parameter int USER_BITS  = USER_WIDTH > 0 ? USER_WIDTH : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    jelly_img_ss_sqrt_if.slave     s_img,
    jelly_img_ss_sqrt_if.master    m_img
);
    localparam int DW      = DATA_WIDTH;
    localparam int SS_W    = 2 * DW;
    localparam int RW      = DW + 2;        // internal remainder width
    localparam int TW      = DW + 3;        // trial subtraction width
    localparam int LATENCY = DW + 2;
    localparam int SB_W    = 5 + USER_BITS + 2 * DW + 1;

    // root pipeline: index 0 is the input register, 1..DW the root stages
    logic [SS_W-1:0] st_ss   [0:DW-1];
    logic [RW-1:0]   st_rem  [0:DW];
    logic [DW-1:0]   st_root [0:DW];
    logic [RW-1:0]   nxt_rem [1:DW];
    logic [DW-1:0]   nxt_root[1:DW];

    logic [DW:0]     mag_q;
    logic [DW:0]     rem_q;
    logic [DW:0]     mag_nxt;
    logic            round_up;

    logic [SB_W-1:0] sb_in;
    logic [SB_W-1:0] sb [0:LATENCY-1];
    logic [4:0]      flags_in;

    // restoring square root: each stage brings down two radicand bits and
    // tries to subtract 4*root+1; success appends a 1 to the root
    always_comb begin
        logic [1:0]    bits;
        logic [TW-1:0] cur;
        logic [TW-1:0] sub;
        logic [TW-1:0] diff;
        bits = '0;
        cur  = '0;
        sub  = '0;
        diff = '0;
        for (int k = 1; k <= DW; k++) begin
            bits = st_ss[k-1][SS_W-2*k +: 2];
            // rem <= 2*root always holds, so its top bit is never needed here
            cur  = {st_rem[k-1][DW:0], bits};
            sub  = {1'b0, st_root[k-1], 2'b01};
            diff = cur - sub;
            if (cur >= sub) begin
                nxt_rem[k]  = diff[RW-1:0];
                nxt_root[k] = {st_root[k-1][DW-2:0], 1'b1};
            end else begin
                nxt_rem[k]  = cur[RW-1:0];
                nxt_root[k] = {st_root[k-1][DW-2:0], 1'b0};
            end
        end
    end

    // nearest rounding: ss - r^2 > r means ss is past the midpoint r^2+r+0.5
    // (a tie is impossible for integers); carry into bit DW is intended
    always_comb begin
        round_up = (st_rem[DW] > {2'b00, st_root[DW]});
        mag_nxt  = {1'b0, st_root[DW]}
                 + {{DW{1'b0}}, (ROUNDING != 0) && round_up};
    end

    // with USE_VALID the flags only mean something on valid pixels
    assign flags_in = {s_img.line_first, s_img.line_last, s_img.pixel_first,
                       s_img.pixel_last, s_img.de}
                    & {5{(USE_VALID == 0) || s_img.valid}};
    assign sb_in    = {flags_in, s_img.user, s_img.x, s_img.y, s_img.valid};

    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int k = 0; k < DW; k++) begin
                st_ss[k] <= '0;
            end
            for (int k = 0; k <= DW; k++) begin
                st_rem[k]  <= '0;
                st_root[k] <= '0;
            end
            for (int k = 0; k < LATENCY; k++) begin
                sb[k] <= '0;
            end
            mag_q <= '0;
            rem_q <= '0;
        end else if (cke) begin
            st_ss[0]   <= s_img.ss;
            st_rem[0]  <= '0;
            st_root[0] <= '0;
            for (int k = 1; k < DW; k++) begin
                st_ss[k] <= st_ss[k-1];
            end
            for (int k = 1; k <= DW; k++) begin
                st_rem[k]  <= nxt_rem[k];
                st_root[k] <= nxt_root[k];
            end
            mag_q <= mag_nxt;
            rem_q <= st_rem[DW][DW:0];
            sb[0] <= sb_in;
            for (int k = 1; k < LATENCY; k++) begin
                sb[k] <= sb[k-1];
            end
        end
    end

    assign {m_img.line_first, m_img.line_last, m_img.pixel_first, m_img.pixel_last,
            m_img.de, m_img.user, m_img.x, m_img.y, m_img.valid} = sb[LATENCY-1];
    assign m_img.mag = mag_q;
    assign m_img.rem = rem_q;
endmodule

// File: tb/tb_jelly_img_ss_sqrt.sv
// Bench for jelly_img_ss_sqrt: two instances (floor and nearest rounding) share one input stream.
// Latency: expected outputs come from a queue of accepted pixels, LATENCY deep.
// Backpressure: cke is toggled randomly; only enabled cycles advance the model.
module tb_jelly_img_ss_sqrt;
    localparam int DW  = 8;
    localparam int UW  = 4;
    localparam int LAT = DW + 2;

    typedef struct {
        logic [4:0]    flags;
        logic [UW-1:0] user;
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [15:0]   ss;
        logic          valid;
    } pix_t;

    logic clk;
    logic rst_n;
    logic cke;

    pix_t q[$];
    pix_t cur;
    pix_t zero_pix;
    int   vec_cnt;
    int   err_cnt;

    jelly_img_ss_sqrt_if #(.USER_BITS(UW), .DATA_WIDTH(DW)) s_if ();
    jelly_img_ss_sqrt_if #(.USER_BITS(UW), .DATA_WIDTH(DW)) m0 ();
    jelly_img_ss_sqrt_if #(.USER_BITS(UW), .DATA_WIDTH(DW)) m1 ();

    jelly_img_ss_sqrt #(.USER_WIDTH(UW), .DATA_WIDTH(DW), .USE_VALID(0), .ROUNDING(0)) u_floor (
        .clk(clk), .reset(rst_n), .cke(cke), .s_img(s_if), .m_img(m0)
    );
    jelly_img_ss_sqrt #(.USER_WIDTH(UW), .DATA_WIDTH(DW), .USE_VALID(0), .ROUNDING(1)) u_round (
        .clk(clk), .reset(rst_n), .cke(cke), .s_img(s_if), .m_img(m1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s @%0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    function automatic int floor_sqrt(input int v);
        int r;
        r = int'($floor($sqrt(real'(v))));
        while (r * r > v) r--;
        while ((r + 1) * (r + 1) <= v) r++;
        return r;
    endfunction

    function automatic pix_t mk_pix(input int ss, input logic vld);
        pix_t p;
        p.flags = {4'($urandom_range(0, 15)), vld};
        p.user  = UW'($urandom_range(0, 15));
        p.x     = DW'($urandom_range(0, 255));
        p.y     = DW'($urandom_range(0, 255));
        p.ss    = 16'(ss);
        p.valid = vld;
        return p;
    endfunction

    task automatic drive(input pix_t p);
        cur = p;
        {s_if.line_first, s_if.line_last, s_if.pixel_first, s_if.pixel_last, s_if.de} = p.flags;
        s_if.user  = p.user;
        s_if.x     = p.x;
        s_if.y     = p.y;
        s_if.ss    = p.ss;
        s_if.valid = p.valid;
    endtask

    // one clock: advance the model with what the DUT sampled, then compare every output
    task automatic tick();
        pix_t e;
        int   r, rm, ru, ss, mg, rr;
        logic [4:0] f0, f1;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            q.delete();
            repeat (LAT) q.push_back(zero_pix);
        end else if (cke) begin
            q.push_back(cur);
            void'(q.pop_front());
        end
        e  = q[0];
        ss = int'(e.ss);
        r  = floor_sqrt(ss);
        rm = ss - r * r;
        ru = ((r + 1) * (r + 1) - ss < ss - r * r) ? r + 1 : r;
        f0 = {m0.line_first, m0.line_last, m0.pixel_first, m0.pixel_last, m0.de};
        f1 = {m1.line_first, m1.line_last, m1.pixel_first, m1.pixel_last, m1.de};
        check("mag_floor",  {23'b0, m0.mag}, r);
        check("rem_floor",  {23'b0, m0.rem}, rm);
        check("mag_round",  {23'b0, m1.mag}, ru);
        check("rem_round",  {23'b0, m1.rem}, rm);
        check("side_floor", {m0.valid, f0, m0.user, m0.x, m0.y}, {e.valid, e.flags, e.user, e.x, e.y});
        check("side_round", {m1.valid, f1, m1.user, m1.x, m1.y}, {e.valid, e.flags, e.user, e.x, e.y});
        mg = int'(m0.mag);
        rr = int'(m0.rem);
        check("inv_sum", mg * mg + rr, ss);
        check("inv_rem", {31'b0, rr <= 2 * mg}, 1);
    endtask

    task automatic run_seq(input int n, input int ss_l[4], input int e_mag0[4],
                           input int e_rem0[4], input int e_mag1[4]);
        for (int t = 1; t <= n + LAT; t++) begin
            if (t <= n) drive(mk_pix(ss_l[t-1], 1'b1));
            else        drive(zero_pix);
            tick();
            if (t >= LAT && t - LAT < n) begin
                check("seq_mag0", {23'b0, m0.mag}, e_mag0[t-LAT]);
                check("seq_rem0", {23'b0, m0.rem}, e_rem0[t-LAT]);
                check("seq_mag1", {23'b0, m1.mag}, e_mag1[t-LAT]);
                check("seq_de",   {31'b0, m0.de},  1);
            end
        end
    endtask

    initial begin
        vec_cnt  = 0;
        err_cnt  = 0;
        zero_pix = '{flags: '0, user: '0, x: '0, y: '0, ss: '0, valid: 1'b0};
        s_if.mag = '0;
        s_if.rem = '0;
        m0.ss    = '0;
        m1.ss    = '0;
        rst_n    = 1'b0;
        cke      = 1'b1;
        drive(zero_pix);
        tick();
        tick();
        check("rst_valid", {31'b0, m0.valid}, 0);
        check("rst_mag",   {23'b0, m1.mag},   0);
        rst_n = 1'b1;

        // single pixel: result appears exactly LAT cycles after it is driven
        drive(mk_pix(144, 1'b1));
        tick();
        drive(zero_pix);
        repeat (LAT - 2) tick();
        check("early_de", {31'b0, m0.de}, 0);
        tick();
        check("lat_mag", {23'b0, m0.mag}, 12);
        check("lat_rem", {23'b0, m0.rem}, 0);
        check("lat_de",  {31'b0, m0.de},  1);

        // boundaries and rounding cases on back-to-back cycles
        run_seq(4, '{0, 65535, 150, 157}, '{0, 255, 12, 12}, '{0, 510, 6, 13}, '{0, 256, 12, 13});

        // reset with pixels in flight: discarded, nothing stale emerges
        for (int i = 0; i < 5; i++) begin
            drive(mk_pix($urandom_range(0, 65535), 1'b1));
            tick();
        end
        drive(zero_pix);
        rst_n = 1'b0;
        tick();
        check("rst_flight_valid", {31'b0, m0.valid}, 0);
        check("rst_flight_mag",   {23'b0, m0.mag},   0);
        check("rst_flight_x",     {24'b0, m1.x},     0);
        rst_n = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            tick();
            check("stale_valid", {31'b0, m0.valid}, 0);
        end
        drive(mk_pix(100, 1'b1));
        tick();
        drive(zero_pix);
        repeat (LAT - 2) tick();
        check("post_rst_early", {31'b0, m0.valid}, 0);
        tick();
        check("post_rst_valid", {31'b0, m0.valid}, 1);
        check("post_rst_mag",   {23'b0, m0.mag},   10);

        // random stream with clock enable low about 30% of cycles
        for (int i = 0; i < 2000; i++) begin
            cke = ($urandom_range(0, 9) >= 3);
            drive(mk_pix($urandom_range(0, 65535), 1'($urandom_range(0, 1))));
            tick();
        end
        cke = 1'b1;

        // exhaustive sweep of the radicand
        for (int i = 0; i < 65536; i++) begin
            drive(mk_pix(i, 1'b1));
            tick();
        end
        drive(zero_pix);
        repeat (LAT) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
